imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Two-port arbiter sharing the single read port of the byte-addressed, little-endian instruction ROM (4096 bytes, window 0xBFC00000–0xBFC00FFF) between the instruction-fetch requester (F) and a data-side requester (D, loads or debug reads from the ROM window). It grants one word-aligned access per cycle with round-robin priority on conflict. It registers the ROM word into a one-entry response stage held until the owning requester accepts it. It rejects misaligned addresses with an error response, and it counts contention cycles.

## Interface
- A_WIDTH, 12, ROM byte-address width; memory depth 2**A_WIDTH bytes
- CNT_WIDTH, 16, width of saturating conflict counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- f_req_valid  in  1  fetch request valid
- f_req_addr  in  A_WIDTH  fetch byte address
- f_req_ready  out  1  fetch request accepted this cycle when high with f_req_valid
- d_req_valid  in  1  data request valid
- d_req_addr  in  A_WIDTH  data byte address
- d_req_ready  out  1  data request accepted this cycle
- mem_a  out  A_WIDTH  address to ROM (combinational read)
- mem_rd  in  32  ROM word {byte A+3, A+2, A+1, A}
- rsp_data  out  32  response word (shared by both ports)
- rsp_err  out  1  response is a misaligned-address error
- f_rsp_valid / d_rsp_valid  out  1 each  response belongs to F / D
- f_rsp_ready / d_rsp_ready  in  1 each  requester consumes response
- conflict_cnt  out  CNT_WIDTH  cycles in which both requests were valid and one was accepted

## Operation
- State: response stage {full, owner∈{F,D}, data, err}; round-robin pointer `last` ∈ {F,D}; conflict_cnt.
- Stage is free when not full, or when full and the owner's rsp_ready is high this cycle (same-cycle drain and refill).
- Grant, only when the stage is free:
  - One valid request: grant it.
  - Both valid: grant the port that is not `last`.
- req_ready for a port = stage free AND that port granted. Never high for both ports. Independent of rsp_ready of the non-owner.
- mem_a = granted address. When nothing is granted, mem_a = F address.
- On accept:
  - Stage loads owner = granted port.
  - Aligned address (addr[1:0]==0): err=0, data=mem_rd.
  - Misaligned address: err=1, data=32'h0.
  - `last` updates to the granted port.
- Stage drains without refill when owner rsp_ready=1 and there is no new accept.
- f_rsp_valid = full & owner==F. d_rsp_valid = full & owner==D. Response fields are stable while valid and not consumed.
- conflict_cnt increments on each accept with both req_valid high. It saturates at all-ones.
- Reset (rst_n=0 at a clock edge):
  - full=0, `last`=D (F wins the first conflict), conflict_cnt=0, rsp_data=0, rsp_err=0.
  - Any in-flight response is discarded.

## Timing
- Accept in cycle N → response valid from cycle N+1. Latency 1 cycle.
- Throughput: 1 access/cycle when the owner holds rsp_ready=1 continuously.
- Backpressure: owner rsp_ready=0 stalls both ports. Both req_ready are 0 until drain.
- All outputs except req_ready and mem_a are registered. req_ready and mem_a are combinational from req_valid, addresses, stage state and owner rsp_ready.
- Reset values take effect the cycle after the rst_n=0 edge. Outputs read 0 during the first cycle after reset except mem_a. No requests are accepted while rst_n=0.
- Requesters must hold valid/addr stable until accepted. Dropping valid before accept is permitted and loses no state.

## Test plan
- Single fetch: ROM bytes 0x00..0x03 = 13 05 A0 00, F reads addr 0x000 → f_req_ready=1 in N; f_rsp_valid=1, rsp_data=32'h00A00513, rsp_err=0 in N+1.
- Conflict round-robin: F and D continuously valid (F 0x004, D 0x010), both rsp_ready=1 → accepts alternate F, D, F, D; conflict_cnt=4 after 4 cycles.
- Backpressure: D response pending with d_rsp_ready=0 for 3 cycles, F valid → f_req_ready=0 for those 3 cycles. rsp_data is unchanged. F is accepted in the cycle d_rsp_ready=1 and f_rsp_valid=1 the next cycle.
- Misaligned: D reads 0x006 → d_rsp_valid=1, rsp_err=1, rsp_data=0. A following aligned D read of 0x008 returns err=0.
- Top address: F reads 0xFFC → word of bytes 0xFFF..0xFFC with no wrap. Saturation: force 2**16 conflict accepts → conflict_cnt holds 16'hFFFF.
- Reset mid-operation: rst_n=0 while a response is pending and requests are valid → next cycle both rsp_valid=0, conflict_cnt=0. After release with both valid, F is granted first.

Source files
------------

// File: rtl/imem_arbiter.sv
// Shares the instruction ROM read port between fetch (F) and data (D) requesters.
// Round-robin on conflict, one-entry registered response stage, misaligned-address errors.
module imem_arbiter #(
  parameter int A_WIDTH   = 12,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 f_req_valid,
  input  logic [A_WIDTH-1:0]   f_req_addr,
  output logic                 f_req_ready,
  input  logic                 d_req_valid,
  input  logic [A_WIDTH-1:0]   d_req_addr,
  output logic                 d_req_ready,
  output logic [A_WIDTH-1:0]   mem_a,
  input  logic [31:0]          mem_rd,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 f_rsp_valid,
  output logic                 d_rsp_valid,
  input  logic                 f_rsp_ready,
  input  logic                 d_rsp_ready,
  output logic [CNT_WIDTH-1:0] conflict_cnt
);

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_e;

  logic                 full_q,  full_d;
  port_e                owner_q, owner_d;
  logic [31:0]          data_q,  data_d;
  logic                 err_q,   err_d;
  port_e                last_q,  last_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

  logic               owner_ready;
  logic               stage_free;
  logic               both_valid;
  logic               grant_f;
  logic               grant_d;
  logic               accept;
  port_e              gnt_port;
  logic [A_WIDTH-1:0] gnt_addr;
  logic               gnt_aligned;

  // Arbitration: a new request is only taken when the stage is empty or being drained
  // this cycle; on conflict the port that did not win last time is served.
  always_comb begin
    owner_ready = (owner_q == PORT_F) ? f_rsp_ready : d_rsp_ready;
    stage_free  = rst_n && (!full_q || owner_ready);
    both_valid  = f_req_valid && d_req_valid;
    grant_f     = stage_free && f_req_valid && (!d_req_valid || (last_q == PORT_D));
    grant_d     = stage_free && d_req_valid && (!f_req_valid || (last_q == PORT_F));
    accept      = grant_f || grant_d;
    gnt_port    = grant_d ? PORT_D : PORT_F;
    gnt_addr    = grant_d ? d_req_addr : f_req_addr;
    gnt_aligned = (gnt_addr[1:0] == 2'b00);
  end

  always_comb begin
    full_d  = full_q;
    owner_d = owner_q;
    data_d  = data_q;
    err_d   = err_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (accept) begin
      full_d  = 1'b1;
      owner_d = gnt_port;
      err_d   = !gnt_aligned;
      data_d  = gnt_aligned ? mem_rd : 32'h0;
      last_d  = gnt_port;
      // Saturate rather than wrap so a long contention burst never reads as low.
      if (both_valid && !(&cnt_q)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (full_q && owner_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      owner_q <= PORT_F;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
      last_q  <= PORT_D;
      cnt_q   <= '0;
    end else begin
      full_q  <= full_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign f_req_ready  = grant_f;
  assign d_req_ready  = grant_d;
  assign mem_a        = gnt_addr;
  assign rsp_data     = data_q;
  assign rsp_err      = err_q;
  assign f_rsp_valid  = full_q && (owner_q == PORT_F);
  assign d_rsp_valid  = full_q && (owner_q == PORT_D);
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed steps from the test plan, a random phase,
// and a counter saturation run, all compared against a transaction-level reference model.
module tb_imem_arbiter;

  localparam int AW     = 12;
  localparam int CW     = 16;
  localparam int NONE   = -1;
  localparam int PF     = 0;
  localparam int PD     = 1;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_req_valid, d_req_valid;
  logic [AW-1:0] f_req_addr, d_req_addr;
  logic          f_req_ready, d_req_ready;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_rd;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          f_rsp_valid, d_rsp_valid;
  logic          f_rsp_ready, d_rsp_ready;
  logic [CW-1:0] conflict_cnt;

  logic [7:0] rom [0:(1<<AW)-1];

  always #5 clk = ~clk;

  // Combinational little-endian ROM word, byte address wraps inside the window.
  assign mem_rd = {rom[mem_a + 12'd3], rom[mem_a + 12'd2], rom[mem_a + 12'd1], rom[mem_a]};

  imem_arbiter #(.A_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .mem_a(mem_a), .mem_rd(mem_rd),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .f_rsp_valid(f_rsp_valid), .d_rsp_valid(d_rsp_valid),
    .f_rsp_ready(f_rsp_ready), .d_rsp_ready(d_rsp_ready),
    .conflict_cnt(conflict_cnt)
  );

  // Reference model: the pending response, who was served most recently, contention count.
  bit          mFull;
  int          mOwner;
  logic [31:0] mData;
  bit          mErr;
  int          mLast;
  int          mCnt;
  int          mWin;

  int total = 0;
  int bad   = 0;

  logic          sFv, sDv;
  logic [AW-1:0] sFa, sDa;
  logic [31:0]   savedWord;

  function automatic logic [31:0] romWord(input int addr);
    return {rom[addr + 3], rom[addr + 2], rom[addr + 1], rom[addr]};
  endfunction

  function automatic logic [AW-1:0] rndAddr();
    logic [AW-1:0] a;
    a = AW'($urandom);
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic fv, input logic [AW-1:0] fa,
                               input logic dv, input logic [AW-1:0] da,
                               input logic fr, input logic dr);
    rst_n       = rn;
    f_req_valid = fv;
    f_req_addr  = fa;
    d_req_valid = dv;
    d_req_addr  = da;
    f_rsp_ready = fr;
    d_rsp_ready = dr;
    #1;
  endtask

  // Decide from the model who should win this cycle, then compare every output.
  task automatic checkOutput(input string tag);
    bit canTake;
    bit ownerTakes;
    ownerTakes = (mOwner == PF) ? f_rsp_ready : d_rsp_ready;
    canTake    = rst_n && (!mFull || ownerTakes);
    if (!canTake)                        mWin = NONE;
    else if (f_req_valid && d_req_valid) mWin = (mLast == PF) ? PD : PF;
    else if (f_req_valid)                mWin = PF;
    else if (d_req_valid)                mWin = PD;
    else                                 mWin = NONE;
    chk($sformatf("%s.f_req_ready", tag), f_req_ready, mWin == PF);
    chk($sformatf("%s.d_req_ready", tag), d_req_ready, mWin == PD);
    chk($sformatf("%s.mem_a", tag), mem_a, (mWin == PD) ? d_req_addr : f_req_addr);
    chk($sformatf("%s.f_rsp_valid", tag), f_rsp_valid, mFull && mOwner == PF);
    chk($sformatf("%s.d_rsp_valid", tag), d_rsp_valid, mFull && mOwner == PD);
    if (mFull) begin
      chk($sformatf("%s.rsp_data", tag), rsp_data, mData);
      chk($sformatf("%s.rsp_err", tag), rsp_err, mErr);
    end
    chk($sformatf("%s.conflict_cnt", tag), conflict_cnt, mCnt);
  endtask

  task automatic clockEdge();
    int  addr;
    bit  ownerTakes;
    @(posedge clk);
    ownerTakes = (mOwner == PF) ? f_rsp_ready : d_rsp_ready;
    if (!rst_n) begin
      mFull = 0; mLast = PD; mCnt = 0; mData = 32'h0; mErr = 0; mOwner = PF;
    end else if (mWin != NONE) begin
      addr   = (mWin == PF) ? int'(f_req_addr) : int'(d_req_addr);
      mErr   = (addr % 4) != 0;
      mData  = mErr ? 32'h0 : romWord(addr);
      if (f_req_valid && d_req_valid && mCnt < CNTMAX) mCnt++;
      mFull  = 1;
      mOwner = mWin;
      mLast  = mWin;
    end else if (mFull && ownerTakes) begin
      mFull = 0;
    end
    #1;
  endtask

  task automatic step(input string tag, input logic rn, input logic fv, input logic [AW-1:0] fa,
                      input logic dv, input logic [AW-1:0] da, input logic fr, input logic dr);
    applyStimulus(rn, fv, fa, dv, da, fr, dr);
    checkOutput(tag);
    clockEdge();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = 8'($urandom);
    rom[0] = 8'h13; rom[1] = 8'h05; rom[2] = 8'hA0; rom[3] = 8'h00;
    mFull = 0; mOwner = PF; mData = 32'h0; mErr = 0; mLast = PD; mCnt = 0; mWin = NONE;

    // Reset and reset state
    applyStimulus(0, 1, 12'h000, 1, 12'h010, 1, 1);
    clockEdge();
    applyStimulus(0, 1, 12'h000, 1, 12'h010, 1, 1);
    checkOutput("reset");
    chk("reset.rsp_data", rsp_data, 32'h0);
    chk("reset.rsp_err", rsp_err, 1'b0);
    clockEdge();

    // Single fetch of address 0
    step("fetch0", 1, 1, 12'h000, 0, 12'h000, 1, 1);
    applyStimulus(1, 0, 12'h000, 0, 12'h000, 1, 1);
    checkOutput("fetch0_rsp");
    chk("fetch0.word", rsp_data, 32'h00A00513);
    chk("fetch0.valid", f_rsp_valid, 1'b1);
    clockEdge();

    // Conflict round-robin from a fresh reset: F, D, F, D
    step("rr_reset", 0, 0, 12'h000, 0, 12'h000, 1, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 12'h004, 1, 12'h010, 1, 1);
      checkOutput("rr");
      chk($sformatf("rr%0d.f_ready", i), f_req_ready, (i % 2) == 0);
      clockEdge();
    end
    applyStimulus(1, 0, 12'h000, 0, 12'h000, 1, 1);
    checkOutput("rr_end");
    chk("rr.cnt4", conflict_cnt, 16'd4);
    clockEdge();

    // Backpressure: D response held for 3 cycles stalls F
    step("bp_d", 1, 0, 12'h000, 1, 12'h020, 1, 1);
    savedWord = romWord(32'h020);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 12'h040, 0, 12'h000, 1, 0);
      checkOutput("bp_hold");
      chk($sformatf("bp%0d.f_ready", i), f_req_ready, 1'b0);
      chk($sformatf("bp%0d.data", i), rsp_data, savedWord);
      clockEdge();
    end
    applyStimulus(1, 1, 12'h040, 0, 12'h000, 1, 1);
    checkOutput("bp_release");
    chk("bp.f_ready_release", f_req_ready, 1'b1);
    clockEdge();

    // Misaligned D read, then aligned D read
    applyStimulus(1, 0, 12'h000, 1, 12'h006, 1, 1);
    checkOutput("mis_req");
    chk("bp.f_rsp_valid", f_rsp_valid, 1'b1);
    clockEdge();
    applyStimulus(1, 0, 12'h000, 1, 12'h008, 1, 1);
    checkOutput("mis_rsp");
    chk("mis.d_valid", d_rsp_valid, 1'b1);
    chk("mis.err", rsp_err, 1'b1);
    chk("mis.data", rsp_data, 32'h0);
    clockEdge();
    applyStimulus(1, 0, 12'h000, 0, 12'h000, 1, 1);
    checkOutput("aligned_rsp");
    chk("aligned.err", rsp_err, 1'b0);
    chk("aligned.data", rsp_data, romWord(8));
    clockEdge();

    // Top of the window
    step("top_req", 1, 1, 12'hFFC, 0, 12'h000, 1, 1);
    applyStimulus(1, 0, 12'h000, 0, 12'h000, 1, 1);
    checkOutput("top_rsp");
    chk("top.data", rsp_data, {rom[4095], rom[4094], rom[4093], rom[4092]});
    clockEdge();

    // Random traffic with held requests and random response backpressure
    sFv = 0; sDv = 0; sFa = 12'h000; sDa = 12'h000;
    for (int i = 0; i < 400; i++) begin
      if (!sFv || mWin == PF) begin sFv = ($urandom_range(0, 3) != 0); sFa = rndAddr(); end
      if (!sDv || mWin == PD) begin sDv = ($urandom_range(0, 2) != 0); sDa = rndAddr(); end
      step("rand", 1, sFv, sFa, sDv, sDa, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end

    // Reset while a response is pending and both ports request
    step("mid_drain", 1, 0, 12'h000, 0, 12'h000, 1, 1);
    step("mid_fill", 1, 1, 12'h100, 0, 12'h000, 0, 0);
    step("mid_stall", 1, 1, 12'h104, 1, 12'h200, 0, 0);
    step("mid_reset", 0, 1, 12'h104, 1, 12'h200, 0, 0);
    applyStimulus(1, 1, 12'h104, 1, 12'h200, 1, 1);
    checkOutput("mid_after");
    chk("mid.f_rsp_valid", f_rsp_valid, 1'b0);
    chk("mid.d_rsp_valid", d_rsp_valid, 1'b0);
    chk("mid.cnt", conflict_cnt, 16'd0);
    chk("mid.f_first", f_req_ready, 1'b1);
    clockEdge();

    // Saturating conflict counter
    for (int i = 0; i < CNTMAX + 5; i++) begin
      step("sat", 1, 1, rndAddr(), 1, rndAddr(), 1, 1);
    end
    applyStimulus(1, 0, 12'h000, 0, 12'h000, 1, 1);
    checkOutput("sat_end");
    chk("sat.cnt", conflict_cnt, 16'hFFFF);
    clockEdge();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
